// File: rtl/systolic_controller.sv
// Systolic-array controller: weight load, activation streaming, skewed valids and drain tracking.
// Optional job cycle counter compiled in with `define SYSTOLIC_CTRL_PERF_EN.
module systolic_controller #(
    parameter int N      = 2,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] num_rows,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] a_base,
    output logic              busy,
    output logic              done,
    output logic              load_weight,
    output logic [ADDR_W-1:0] w_addr,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [N-1:0]      valid,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [15:0]       perf_cycles
);

    localparam int PIPE_W = 2 * N - 1;
    localparam int DR_W   = $clog2(2 * N) + 1;
    localparam int CNT_W  = (ADDR_W + 1 > DR_W) ? ADDR_W + 1 : DR_W;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_W = 3'd1;
    localparam logic [2:0] STREAM = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]        state_r;
    logic [2:0]        state_s;
    logic [CNT_W-1:0]  idx_r;
    logic [CNT_W-1:0]  idx_s;
    logic [ADDR_W-1:0] rows_r;
    logic [ADDR_W-1:0] w_base_r;
    logic [ADDR_W-1:0] a_base_r;
    logic [ADDR_W-1:0] ocnt_r;
    logic [PIPE_W-1:0] pipe_r;
    logic              accept_s;
    logic              kill_s;
    logic              lw_s;
    logic              ard_s;
    logic              ov_s;

    // Abort only matters once a job is running; start is only honoured in IDLE.
    always_comb begin
        accept_s = (state_r == IDLE) && start;
        kill_s   = (state_r != IDLE) && abort;
        lw_s     = (state_r == LOAD_W) && !kill_s;
        ard_s    = (state_r == STREAM) && !kill_s;
        ov_s     = pipe_r[PIPE_W-1] && !kill_s;
    end

    // Next-state and phase counter; idx counts edges spent in the current phase.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = LOAD_W;
                    idx_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD_W: begin
                if (idx_r == CNT_W'(N - 1)) begin
                    idx_s   = {CNT_W{1'b0}};
                    state_s = (rows_r == {ADDR_W{1'b0}}) ? DONE : STREAM;
                end else begin
                    idx_s = idx_r + CNT_W'(1);
                end
            end
            STREAM: begin
                if (idx_r + CNT_W'(1) == CNT_W'(rows_r)) begin
                    idx_s   = {CNT_W{1'b0}};
                    state_s = DRAIN;
                end else begin
                    idx_s = idx_r + CNT_W'(1);
                end
            end
            DRAIN: begin
                // The last activation needs 2N more edges to leave the array.
                if (idx_r == CNT_W'(2 * N - 1)) begin
                    idx_s   = {CNT_W{1'b0}};
                    state_s = DONE;
                end else begin
                    idx_s = idx_r + CNT_W'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                idx_s   = {CNT_W{1'b0}};
            end
        endcase
        if (kill_s) begin
            state_s = IDLE;
            idx_s   = {CNT_W{1'b0}};
        end else begin
            state_s = state_s;
        end
    end

    // State, latched job parameters and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            idx_r       <= {CNT_W{1'b0}};
            rows_r      <= {ADDR_W{1'b0}};
            w_base_r    <= {ADDR_W{1'b0}};
            a_base_r    <= {ADDR_W{1'b0}};
            ocnt_r      <= {ADDR_W{1'b0}};
            pipe_r      <= {PIPE_W{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            load_weight <= 1'b0;
            w_addr      <= {ADDR_W{1'b0}};
            a_rd_en     <= 1'b0;
            a_addr      <= {ADDR_W{1'b0}};
            out_valid   <= 1'b0;
            out_addr    <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            if (accept_s) begin
                rows_r   <= num_rows;
                w_base_r <= w_base;
                a_base_r <= a_base;
                ocnt_r   <= {ADDR_W{1'b0}};
            end else if (ov_s) begin
                ocnt_r <= ocnt_r + ADDR_W'(1);
            end
            busy        <= (state_r != IDLE) && !kill_s;
            done        <= (state_r == DONE) && !kill_s;
            load_weight <= lw_s;
            w_addr      <= lw_s ? w_base_r + ADDR_W'(idx_r) : {ADDR_W{1'b0}};
            a_rd_en     <= ard_s;
            a_addr      <= ard_s ? a_base_r + ADDR_W'(idx_r) : {ADDR_W{1'b0}};
            // Tap r of this shift line is a_rd_en delayed by r+1 edges.
            pipe_r      <= kill_s ? {PIPE_W{1'b0}} : ((pipe_r << 1) | PIPE_W'(a_rd_en));
            out_valid   <= ov_s;
            out_addr    <= ov_s ? ocnt_r : {ADDR_W{1'b0}};
        end
    end

    assign valid = pipe_r[N-1:0];

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [15:0] perf_r;

    // Counts busy cycles of the current job, saturating, held until the next start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_r <= 16'h0000;
        end else if (accept_s) begin
            perf_r <= 16'h0000;
        end else if ((state_r != IDLE) && !kill_s && (perf_r != 16'hFFFF)) begin
            perf_r <= perf_r + 16'h0001;
        end
    end

    assign perf_cycles = perf_r;
`else
    assign perf_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_systolic_controller.sv
// Directed self-checking bench for systolic_controller (N=2, ADDR_W=8).
module tb_systolic_controller;

    localparam int N = 2;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [7:0] num_rows;
    logic [7:0] w_base;
    logic [7:0] a_base;
    logic       busy;
    logic       done;
    logic       load_weight;
    logic [7:0] w_addr;
    logic       a_rd_en;
    logic [7:0] a_addr;
    logic [1:0] valid;
    logic       out_valid;
    logic [7:0] out_addr;
    logic [15:0] perf_cycles;

    int checks;
    int failures;

    systolic_controller #(.N(N), .ADDR_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .num_rows(num_rows), .w_base(w_base), .a_base(a_base),
        .busy(busy), .done(done), .load_weight(load_weight), .w_addr(w_addr),
        .a_rd_en(a_rd_en), .a_addr(a_addr), .valid(valid),
        .out_valid(out_valid), .out_addr(out_addr), .perf_cycles(perf_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input int cyc);
        chk({tag, "_busy"}, cyc, 32'(busy), 32'd0);
        chk({tag, "_done"}, cyc, 32'(done), 32'd0);
        chk({tag, "_lw"}, cyc, 32'(load_weight), 32'd0);
        chk({tag, "_waddr"}, cyc, 32'(w_addr), 32'd0);
        chk({tag, "_ard"}, cyc, 32'(a_rd_en), 32'd0);
        chk({tag, "_aaddr"}, cyc, 32'(a_addr), 32'd0);
        chk({tag, "_valid"}, cyc, 32'(valid), 32'd0);
        chk({tag, "_ov"}, cyc, 32'(out_valid), 32'd0);
        chk({tag, "_oaddr"}, cyc, 32'(out_addr), 32'd0);
    endtask

    // Called #1 after an edge; start is sampled on the following edge (cycle 0).
    task automatic run_job(input string tag, input int r, input int wb, input int ab, input int last,
                           input int restart_at, input int abort_at, input int reset_at,
                           input bit abort_with_start);
        int d;
        int lw, wa, ard, aa, v0, v1, ov, oa, dn, bz, pc;
        d = (r == 0) ? N + 1 : 3 * N + r + 1;
        num_rows = 8'(r);
        w_base   = 8'(wb);
        a_base   = 8'(ab);
        start    = 1'b1;
        abort    = abort_with_start;
        @(posedge clk);
        #1;
        start    = 1'b0;
        abort    = 1'b0;
        num_rows = 8'h00;
        w_base   = 8'h00;
        a_base   = 8'h00;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            abort = 1'b0;
            lw  = (c >= 1 && c <= N) ? 1 : 0;
            wa  = lw ? ((wb + c - 1) & 255) : 0;
            ard = (r > 0 && c >= N + 1 && c <= N + r) ? 1 : 0;
            aa  = ard ? ((ab + c - N - 1) & 255) : 0;
            v0  = (r > 0 && c >= N + 2 && c <= N + 1 + r) ? 1 : 0;
            v1  = (r > 0 && c >= N + 3 && c <= N + 2 + r) ? 1 : 0;
            ov  = (r > 0 && c >= 3 * N + 1 && c <= 3 * N + r) ? 1 : 0;
            oa  = ov ? (c - 3 * N - 1) : 0;
            dn  = (c == d) ? 1 : 0;
            bz  = (c >= 1 && c <= d) ? 1 : 0;
            pc  = (c < d) ? c : d;
            if (abort_at != 0 && c >= abort_at) begin
                lw = 0; wa = 0; ard = 0; aa = 0; v0 = 0; v1 = 0; ov = 0; oa = 0; dn = 0; bz = 0;
            end
            chk({tag, "_busy"}, c, 32'(busy), 32'(bz));
            chk({tag, "_done"}, c, 32'(done), 32'(dn));
            chk({tag, "_lw"}, c, 32'(load_weight), 32'(lw));
            chk({tag, "_waddr"}, c, 32'(w_addr), 32'(wa));
            chk({tag, "_ard"}, c, 32'(a_rd_en), 32'(ard));
            chk({tag, "_aaddr"}, c, 32'(a_addr), 32'(aa));
            chk({tag, "_valid"}, c, 32'(valid), 32'((v1 << 1) | v0));
            chk({tag, "_ov"}, c, 32'(out_valid), 32'(ov));
            chk({tag, "_oaddr"}, c, 32'(out_addr), 32'(oa));
            if (abort_at == 0) begin
`ifdef SYSTOLIC_CTRL_PERF_EN
                chk({tag, "_perf"}, c, 32'(perf_cycles), 32'(pc));
`else
                chk({tag, "_perf"}, c, 32'(perf_cycles), 32'd0);
`endif
            end
            if (c + 1 == restart_at) start = 1'b1;
            if (c + 1 == abort_at) abort = 1'b1;
            if (c == reset_at) begin
                #2 reset_n = 1'b0;
                #1;
                chk_quiet({tag, "_inrst"}, c);
                chk({tag, "_inrst_perf"}, c, 32'(perf_cycles), 32'd0);
                #2 reset_n = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        num_rows = 8'h00;
        w_base   = 8'h00;
        a_base   = 8'h00;
        #12;
        chk_quiet("rst", 0);
        chk("rst_perf", 0, 32'(perf_cycles), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk_quiet("idle", 0);

        run_job("basic", 3, 8'h10, 8'h20, 12, 0, 0, 0, 1'b0);
        run_job("r0", 0, 8'h10, 8'h20, 5, 0, 0, 0, 1'b0);
        run_job("abort", 3, 8'h10, 8'h20, 5, 0, 5, 0, 1'b0);
        run_job("after_abort", 3, 8'h10, 8'h20, 12, 0, 0, 0, 1'b0);
        run_job("restart", 3, 8'h10, 8'h20, 12, 4, 0, 0, 1'b0);
        run_job("wrap", 3, 8'h40, 8'hFE, 12, 0, 0, 0, 1'b0);
        run_job("abort_start", 2, 8'hFF, 8'h05, 11, 0, 0, 0, 1'b1);
        run_job("reset_mid", 3, 8'h10, 8'h20, 4, 0, 0, 4, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk_quiet("post_rst", k);
        end
        run_job("post_rst_job", 3, 8'h10, 8'h20, 12, 0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_controller.md
SYSTOLIC_CONTROLLER -- requirements
Module: systolic_controller

Interface
REQ-001 SHALL have parameter N, default 2, meaning the array dimension (N x N processing elements).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning the buffer address width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic uses its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to run one weight-load plus stream job.
REQ-006 SHALL have port abort  input  1  synchronous cancel of the job in progress.
REQ-007 SHALL have port num_rows  input  ADDR_W  number of activation rows R, sampled when start is accepted.
REQ-008 SHALL have ports w_base and a_base  input  ADDR_W each  weight and activation base addresses, sampled when start is accepted.
REQ-009 SHALL have port busy  output  1  high while a job is in progress.
REQ-010 SHALL have port done  output  1  single-cycle completion pulse.
REQ-011 SHALL have ports load_weight (output, 1) and w_addr (output, ADDR_W), which form the weight-load strobe and weight buffer read address.
REQ-012 SHALL have ports a_rd_en (output, 1) and a_addr (output, ADDR_W), which form the activation buffer read; the buffer has 1-cycle read latency.
REQ-013 SHALL have port valid  output  N  per-array-row valid, skewed by row.
REQ-014 SHALL have ports out_valid (output, 1) and out_addr (output, ADDR_W), which mark a finished accumulator row and its result index.
REQ-015 SHALL have port perf_cycles  output  16  job cycle count (see Configuration).

Function
REQ-016 SHALL implement the states IDLE, LOAD_W, STREAM, DRAIN and DONE; cycle 0 is the edge at which start is sampled high in IDLE.
REQ-017 SHALL accept start only in IDLE; start in any other state SHALL be ignored, with no queuing.
REQ-018 SHALL, in LOAD_W, drive load_weight=1 for cycles 1..N with w_addr=w_base+i on cycle i+1 (i=0..N-1), then go to STREAM.
REQ-019 SHALL, in STREAM, drive a_rd_en=1 for cycles N+1..N+R with a_addr=a_base+k on cycle N+1+k.
REQ-020 SHALL assert valid[r] on cycles N+2+r..N+1+r+R, i.e. a_rd_en delayed by 1+r cycles.
REQ-021 SHALL assert out_valid on cycles 3N+1..3N+R (a_rd_en delayed by 2N) with out_addr=k for the k-th pulse, counting from 0.
REQ-022 SHALL stay in DRAIN until the last out_valid, then pulse done for exactly one cycle (cycle 3N+R+1) in DONE, then return to IDLE.
REQ-023 SHALL, when R=0, skip STREAM and DRAIN, pulse done on cycle N+1, and never assert a_rd_en, valid or out_valid.
REQ-024 SHALL drive busy=1 from cycle 1 through the done cycle inclusive, and 0 in IDLE.
REQ-025 SHALL compute address arithmetic modulo 2^ADDR_W, with silent wrap-around.
REQ-026 SHALL, on abort in any non-IDLE state, go to IDLE at the next edge, deassert all strobes and pending skewed valids at that edge, and not pulse done.
REQ-027 SHALL ignore abort in IDLE; when abort and start are both high in IDLE, start SHALL be accepted.

Reset
REQ-028 SHALL, while reset_n=0, immediately put the state in IDLE and clear all counters, skew pipelines and latched inputs.
REQ-029 SHALL hold busy, done, load_weight, a_rd_en, valid, out_valid, w_addr, a_addr, out_addr and perf_cycles at 0 during reset.
REQ-030 SHALL make reset assertion mid-job discard the job with no done pulse; the block SHALL leave reset idle.

Configuration
REQ-031 SHALL use the macro SYSTOLIC_CTRL_PERF_EN to compile the performance counter in or out.
REQ-032 SHALL, with SYSTOLIC_CTRL_PERF_EN defined, clear perf_cycles on start acceptance, increment it each busy cycle saturating at 16'hFFFF, and hold it after done until the next start.
REQ-033 SHALL, with SYSTOLIC_CTRL_PERF_EN undefined, keep the port present, tie perf_cycles to 0 and add no counter logic.

Verification
REQ-034 SHALL cover N=2, R=3, w_base=8'h10, a_base=8'h20: load_weight on cycles 1-2 (w_addr 10,11); a_rd_en on cycles 3-5 (a_addr 20,21,22); valid[0] on 4-6; valid[1] on 5-7; out_valid on 7-9 (out_addr 0,1,2); done on 10; busy on 1-10.
REQ-035 SHALL cover N=2, R=0: load_weight on cycles 1-2, done on cycle 3, and no a_rd_en, valid or out_valid.
REQ-036 SHALL cover N=2, R=3 with abort on cycle 4: all outputs 0 from cycle 5, no done, and a new start on cycle 6 runs a correct full job.
REQ-037 SHALL cover start re-pulsed on cycle 4 of a running job: it is ignored and the timing matches REQ-034.
REQ-038 SHALL cover a_base=8'hFE, R=3: a_addr sequence FE, FF, 00.
REQ-039 SHALL cover reset_n pulsed low mid-STREAM: outputs go to 0 immediately with no done, and with SYSTOLIC_CTRL_PERF_EN defined the REQ-034 job reads perf_cycles=10 after done.
